// File: rtl/aes128_round_engine.sv
// Iterative AES-128 encryption engine: one round per clock, valid/ready in and out.
// Build option: define AES_KEY_LATCH_EN to capture round_keys on the accept edge.
// Without it, round_keys is read live and must stay stable until out_valid is high.
// Also contains the byte S-box (sbox) used sixteen times for SubBytes.

module sbox (
  input  logic [7:0] input_byte,
  output logic [7:0] output_byte
);

  // GF(2^8) multiply, reduction polynomial 0x11B
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // Multiplicative inverse as x^254 (0 maps to 0), then the affine transform
  always_comb begin
    sq  = input_byte;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    output_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

module aes128_round_engine (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  plaintext,
  input  logic [1407:0] round_keys,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  ciphertext,
  output logic          busy
);

  localparam int unsigned BLK_W   = 128;
  localparam int unsigned KEYS_W  = 1408;
  localparam int unsigned N_ROUND = 10;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t             state_q, state_nxt;
  logic [3:0]         rnd_q, rnd_nxt;
  logic [BLK_W-1:0]   blk_q, blk_nxt;
  logic [KEYS_W-1:0]  keys;
  logic [BLK_W-1:0]   rk_sel;
  logic [BLK_W-1:0]   sub;
  logic [BLK_W-1:0]   sr;
  logic [BLK_W-1:0]   round_out;
  logic               accept;

  assign accept = in_valid && in_ready;

`ifdef AES_KEY_LATCH_EN
  logic [KEYS_W-1:0] key_q;

  // Private copy of the key schedule, taken when a block is accepted
  always_ff @(posedge clk) begin
    if (!rst && state_q == IDLE && accept) key_q <= round_keys;
  end

  assign keys = key_q;
`else
  assign keys = round_keys;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Byte (row r, column c) lives at index r + 4*c, byte 0 in the MSBs
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  // SubBytes: one S-box per state byte
  for (genvar i = 0; i < 16; i++) begin : g_sbox
    sbox u_sbox (
      .input_byte  (blk_q[127-8*i -: 8]),
      .output_byte (sub[127-8*i -: 8])
    );
  end

  // Round key select and round function; the final round skips MixColumns
  always_comb begin
    rk_sel = '0;
    for (int r = 0; r <= int'(N_ROUND); r++) begin
      if (rnd_q == 4'(r)) rk_sel = keys[KEYS_W-1-128*r -: 128];
    end
    sr = shift_rows(sub);
    if (rnd_q == 4'(N_ROUND)) round_out = sr ^ rk_sel;
    else                      round_out = mix_columns(sr) ^ rk_sel;
  end

  // Next-state and datapath update
  always_comb begin
    state_nxt = state_q;
    rnd_nxt   = rnd_q;
    blk_nxt   = blk_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          blk_nxt   = plaintext ^ round_keys[KEYS_W-1 -: 128];
          rnd_nxt   = 4'd1;
          state_nxt = ROUND;
        end
      end
      ROUND: begin
        blk_nxt = round_out;
        if (rnd_q == 4'(N_ROUND)) begin
          rnd_nxt   = 4'd0;
          state_nxt = DONE;
        end else begin
          rnd_nxt = rnd_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register with registered handshake/status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rnd_q     <= '0;
      blk_q     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      rnd_q     <= rnd_nxt;
      blk_q     <= blk_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      busy      <= (state_nxt != IDLE);
    end
  end

  assign ciphertext = blk_q;

endmodule
